// File: rtl/div_seq.sv
// Multi-cycle restoring divider (quotient -> lo, remainder -> hi) with a
// start/busy/done handshake, signed/unsigned mode and divide-by-zero flag.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only when the unit is idle (including the
  // cycle done is high); busy is high from the accepting edge until the edge
  // that raises done; done is a one-cycle pulse marking hi/lo/div_zero valid.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift, rem_sub;
  logic             rem_ge;

  // Negating the most negative value yields 2^(WIDTH-1), read as unsigned.
  assign a_mag = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign b_mag = (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;

  assign rem_shift = {rem_q[WIDTH-1:0], dvd_q[cnt_q]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
  assign rem_sub   = rem_shift - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    zero_d     = zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          div_zero_d = 1'b0;
          busy_d     = 1'b1;
          rem_d      = '0;
          quo_d      = '0;
          cnt_d      = CNT_MAX;
          if (B == '0) begin
            zero_d  = 1'b1;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = ST_FIX;
          end else begin
            zero_d  = 1'b0;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            q_neg_d = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_d = is_signed & A[WIDTH-1];
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        // One quotient bit per cycle, MSB first; quotient shifts in from the right.
        rem_d = rem_ge ? rem_sub : rem_shift;
        quo_d = {quo_q[WIDTH-2:0], rem_ge};
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_FIX: begin
        if (zero_q) begin
          div_zero_d = 1'b1;
        end else begin
          lo_d = q_neg_q ? (~quo_q + 1'b1) : quo_q;
          hi_d = r_neg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      zero_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      zero_q     <= zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign div_zero  = div_zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq (WIDTH=32): directed corner cases plus random
// operands, checked against a plain-arithmetic reference.
module tb_div_seq;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;
  logic [1:0]   dbg_state;

  div_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {div_zero, hi, lo}
  logic [2*W:0] exp_q[$];
  logic [W-1:0] model_lo = '0;
  logic [W-1:0] model_hi = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain 64-bit integer division (truncating toward zero)
  task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == '0) begin
      exp_q.push_back({1'b1, model_hi, model_lo});
    end else begin
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      model_lo = qv[W-1:0];
      model_hi = rv[W-1:0];
      exp_q.push_back({1'b0, model_hi, model_lo});
    end
  endtask

  // monitor: compares every done pulse against the scoreboard
  initial begin
    logic         prev_done;
    logic [2*W:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 1'b0;
      end else begin
        if (done) begin
          check("done_one_cycle", {63'd0, prev_done}, 64'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("lo", {32'd0, lo}, {32'd0, e[W-1:0]});
            check("hi", {32'd0, hi}, {32'd0, e[2*W-1:W]});
            check("div_zero", {63'd0, div_zero}, {63'd0, e[2*W]});
          end
        end
        prev_done = done;
      end
    end
  end

  // driver: called #1 after a rising edge; returns #1 after the done edge so
  // the next call issues start in the done cycle (back-to-back).
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic poke);
    int  lat;
    int  exp_lat;
    logic got;
    logic busy_ok;
    model_push(a, b, s);
    A = a; B = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom; is_signed = 1'($urandom_range(0, 1));
    exp_lat = (b == '0) ? 1 : W + 1;
    lat = 0; got = 1'b0; busy_ok = 1'b1;
    for (int c = 1; c <= 100 && !got; c++) begin
      start = (poke && c == 5) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        lat = c;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    start = 1'b0;
    check("done_timeout", {63'd0, got}, 64'd1);
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_during_op", {63'd0, busy_ok}, 64'd1);
    check("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lo"}, {32'd0, lo}, 64'd0);
    check({tag, "_hi"}, {32'd0, hi}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_div_zero"}, {63'd0, div_zero}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic s;
    int r;
    logic quiet;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // directed corners
    do_div(32'd7, 32'd2, 1'b1, 1'b0);
    do_div(-32'sd7, 32'd2, 1'b1, 1'b0);
    do_div(32'd7, -32'sd2, 1'b1, 1'b0);
    do_div(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    do_div(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_div(32'd7, 32'd2, 1'b1, 1'b0);
    do_div(32'd5, 32'd0, 1'b1, 1'b0);
    do_div(32'd5, 32'd0, 1'b0, 1'b0);
    do_div(32'd100, 32'd7, 1'b0, 1'b0);
    do_div(32'd3, 32'd9, 1'b1, 1'b0);

    // start pulsed while busy must be ignored
    do_div(32'd1000, 32'd3, 1'b0, 1'b1);
    do_div(-32'sd1000, 32'd3, 1'b1, 1'b1);

    // random operands, back-to-back
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0)      b = '0;
      else if (r < 4)  b = W'($urandom_range(1, 15));
      else if (r == 4) b = '1;
      else             b = $urandom;
      if (r == 5) a = 32'h8000_0000;
      if (r < 4 && s && $urandom_range(0, 1) == 1) b = ~b + 1'b1;
      do_div(a, b, s, 1'($urandom_range(0, 3) == 0));
    end

    // reset mid-operation drops the op: all outputs clear, no done follows
    A = 32'd100; B = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    model_lo = '0;
    model_hi = '0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) quiet = 1'b0;
    end
    check("no_done_after_reset", {63'd0, quiet}, 64'd1);

    // divide-by-zero right after reset holds the cleared hi/lo
    do_div(32'd9, 32'd0, 1'b0, 1'b0);
    do_div(32'd9, 32'd4, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
